// File: rtl/if_id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// if_id_hazard_ctrl
//
// Controls the front of the pipeline (PC and the IF/ID instruction register)
// for three kinds of hazard, highest priority first:
//   1. taken branch/jump resolved in EX -> flush IF/ID for FLUSH_CYCLES cycles
//   2. load-use hazard                  -> exactly one stall/bubble cycle
//   3. instruction memory not ready     -> hold PC and IR until data is valid
//
// Parameters
//   FLUSH_CYCLES     cycles ir_flush is held after a taken branch (1..15)
//
// Optional build macro
//   HAZARD_PERF_CNT_EN  when defined, builds a saturating 16-bit counter of
//                       cycles with pc_en=0; otherwise stall_count is tied to 0
//
// Ports
//   clk              clock
//   rst_ctrl         asynchronous active-high reset
//   inst_id[31:0]    instruction currently held in IF/ID
//   dest_ex[4:0]     destination register of the EX-stage instruction
//   memread_ex       EX-stage instruction is a load
//   branch_taken_ex  EX stage resolved a taken branch or jump
//   imem_ready       instruction memory data valid this cycle
//   pc_en            PC write enable
//   ir_en            IF/ID instruction register load enable
//   ir_flush         clears the IF/ID instruction register to 32'b0
//   id_bubble        zeroes ID/EX control signals
//   ctrl_state[1:0]  registered state (RUN=0, LU_STALL=1, FLUSH=2, IMEM_WAIT=3)
//   stall_count[15:0] stall performance counter
// ---------------------------------------------------------------------------
module if_id_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_ctrl,
    input  logic [31:0] inst_id,
    input  logic [4:0]  dest_ex,
    input  logic        memread_ex,
    input  logic        branch_taken_ex,
    input  logic        imem_ready,
    output logic        pc_en,
    output logic        ir_en,
    output logic        ir_flush,
    output logic        id_bubble,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        FLUSH     = 2'd2,
        IMEM_WAIT = 2'd3
    } state_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Value loaded into the flush counter on a taken branch: the branch cycle
    // itself is the first flush cycle, FLUSH covers the remaining ones.
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;

    // -----------------------------------------------------------------------
    // Load-use hazard detection
    // -----------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rs1_id, rs2_id;
    logic       uses_rs2;
    logic       hz;

    assign opcode   = inst_id[6:0];
    assign rs1_id   = inst_id[19:15];
    assign rs2_id   = inst_id[24:20];

    // Only R-type, stores and conditional branches read rs2; for other
    // formats bits [24:20] are immediate bits and must not raise a hazard.
    assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    assign hz = memread_ex && (dest_ex != 5'd0) &&
                ((dest_ex == rs1_id) || (uses_rs2 && (dest_ex == rs2_id)));

    // Fields of inst_id that play no part in hazard detection.
    logic unused_inst_bits;
    assign unused_inst_bits = &{1'b0, inst_id[31:25], inst_id[14:7]};

    // -----------------------------------------------------------------------
    // State and flush counter registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    // NOTE: every signal written here is given a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pc_en       = 1'b0;
        ir_en       = 1'b0;
        ir_flush    = 1'b0;
        id_bubble   = 1'b1;

        case (state_q)
            FLUSH: begin
                ir_flush = 1'b1;
                if (branch_taken_ex) begin
                    // A fresh redirect restarts the flush window and lets the
                    // PC take the new target this cycle.
                    pc_en       = 1'b1;
                    flush_cnt_d = FLUSH_RELOAD;
                    state_d     = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                end else if (flush_cnt_q <= 4'd1) begin
                    flush_cnt_d = 4'd0;
                    state_d     = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end

            // RUN, LU_STALL and IMEM_WAIT share one priority chain; LU_STALL
            // only differs in masking hz, which guarantees the stall lasts a
            // single cycle even though IF/ID still holds the same instruction.
            default: begin
                if (branch_taken_ex) begin
                    pc_en       = 1'b1;
                    ir_flush    = 1'b1;
                    flush_cnt_d = FLUSH_RELOAD;
                    state_d     = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                end else if (hz && (state_q != LU_STALL)) begin
                    state_d = LU_STALL;
                end else if (!imem_ready) begin
                    state_d = IMEM_WAIT;
                end else begin
                    pc_en     = 1'b1;
                    ir_en     = 1'b1;
                    id_bubble = 1'b0;
                    state_d   = RUN;
                end
            end
        endcase

        // Reset must reach the outputs without waiting for a clock edge, and
        // the RUN decode above would otherwise follow the live inputs.
        if (rst_ctrl) begin
            pc_en     = 1'b0;
            ir_en     = 1'b0;
            ir_flush  = 1'b1;
            id_bubble = 1'b1;
        end
    end

    assign ctrl_state = state_q;

    // -----------------------------------------------------------------------
    // Optional stall performance counter
    // -----------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst_ctrl) begin
        if (rst_ctrl)
            stall_cnt_q <= 16'h0000;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule
